// File: rtl/peak_to_note.sv
// Maps per-frame FFT peak bins to MIDI notes via an elaboration-time boundary
// table and a 7-step binary search, then debounces into note-on/off events.
module peak_to_note #(
  parameter int FFT_SIZE       = 4096,
  parameter int SAMPLE_RATE_HZ = 24000,
  parameter int STABLE_FRAMES  = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [12:0] peak_in,
  input  logic        peak_valid_in,
  output logic [6:0]  note_out,
  output logic        note_valid_out,
  output logic        note_on_out,
  output logic        note_off_out,
  output logic [6:0]  off_note_out,
  output logic        busy_out,
  output logic        drop_out
);

  // state  | meaning
  // IDLE   | waiting for a peak strobe
  // SEARCH | one binary-search comparison per cycle, 7 cycles
  // UPDATE | resolve the note and apply the debounce step
  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE} state_t;

  localparam logic [6:0] NOTE_NONE = 7'd0;
  localparam logic [3:0] STABLE    = 4'(STABLE_FRAMES);

  // Lower edge of note 21+i: half a semitone below its nominal frequency.
  function automatic int bound_calc(input int i);
    real f;
    f = real'(FFT_SIZE) * 440.0 * (2.0 ** ((real'(i) - 48.5) / 12.0))
        / real'(SAMPLE_RATE_HZ);
    return $rtoi($ceil(f));
  endfunction

  // Padded to 128 entries with an unreachable bound so the search needs no range guard.
  logic [15:0] btab [0:127];
  for (genvar g = 0; g < 128; g++) begin : g_btab
    if (g <= 88) begin : g_real
      assign btab[g] = 16'(bound_calc(g));
    end else begin : g_pad
      assign btab[g] = 16'hFFFF;
    end
  end

  state_t      state;
  logic [12:0] bin_q;
  logic [6:0]  idx_q;
  logic [2:0]  step_q;
  logic [6:0]  cand_q;
  logic [3:0]  cnt_q;

  logic [6:0]  try_idx;
  logic [15:0] bin_ext;
  logic [6:0]  result;
  logic [6:0]  held_code;
  logic [6:0]  new_cand;
  logic [3:0]  new_cnt;
  logic        change;

  always_comb begin
    bin_ext   = {3'b000, bin_q};
    try_idx   = idx_q | (7'd64 >> step_q);
    held_code = note_valid_out ? note_out : NOTE_NONE;
    if ((bin_ext < btab[0]) || (idx_q >= 7'd88)) result = NOTE_NONE;
    else                                          result = idx_q + 7'd21;
    new_cand = cand_q;
    new_cnt  = cnt_q;
    if (result == cand_q) begin
      if (cnt_q < STABLE) new_cnt = cnt_q + 4'd1;
    end else begin
      new_cand = result;
      new_cnt  = 4'd1;
    end
    change = (new_cnt == STABLE) && (new_cand != held_code);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      bin_q          <= '0;
      idx_q          <= '0;
      step_q         <= '0;
      cand_q         <= NOTE_NONE;
      cnt_q          <= '0;
      note_out       <= '0;
      note_valid_out <= 1'b0;
      note_on_out    <= 1'b0;
      note_off_out   <= 1'b0;
      off_note_out   <= '0;
      busy_out       <= 1'b0;
      drop_out       <= 1'b0;
    end else begin
      note_on_out  <= 1'b0;
      note_off_out <= 1'b0;
      drop_out     <= peak_valid_in && busy_out;
      case (state)
        IDLE: begin
          if (peak_valid_in) begin
            bin_q    <= peak_in;
            idx_q    <= '0;
            step_q   <= '0;
            busy_out <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (bin_ext >= btab[try_idx]) idx_q <= try_idx;
          step_q <= step_q + 3'd1;
          if (step_q == 3'd6) state <= UPDATE;
        end
        UPDATE: begin
          cand_q   <= new_cand;
          cnt_q    <= new_cnt;
          busy_out <= 1'b0;
          state    <= IDLE;
          if (change) begin
            if (note_valid_out) begin
              note_off_out <= 1'b1;
              off_note_out <= note_out;
            end
            if (new_cand != NOTE_NONE) begin
              note_on_out    <= 1'b1;
              note_out       <= new_cand;
              note_valid_out <= 1'b1;
            end else begin
              note_valid_out <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_to_note.sv
// Directed bench for peak_to_note: note mapping, debounce, drops, mid-search
// reset, and a STABLE_FRAMES=1 instance.
module tb_peak_to_note;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [12:0] peak_in = '0;
  logic        peak_valid_in = 1'b0;
  logic        valid2 = 1'b0;

  logic [6:0] note_out, off_note_out, note2, off_note2;
  logic       note_valid_out, note_on_out, note_off_out, busy_out, drop_out;
  logic       nvalid2, on2, off2, busy2, drop2;

  int n_checks = 0;
  int n_fail   = 0;

  peak_to_note dut (
    .clk_in(clk_in), .rst_in(rst_in), .peak_in(peak_in), .peak_valid_in(peak_valid_in),
    .note_out(note_out), .note_valid_out(note_valid_out), .note_on_out(note_on_out),
    .note_off_out(note_off_out), .off_note_out(off_note_out), .busy_out(busy_out),
    .drop_out(drop_out)
  );

  peak_to_note #(.STABLE_FRAMES(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .peak_in(peak_in), .peak_valid_in(valid2),
    .note_out(note2), .note_valid_out(nvalid2), .note_on_out(on2),
    .note_off_out(off2), .off_note_out(off_note2), .busy_out(busy2),
    .drop_out(drop2)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Strobe one frame and check busy, pulses and held note through t+10.
  task automatic run_frame(input string tag, input logic [12:0] pk,
                           input logic e_on, input logic e_off, input int e_off_note,
                           input int e_note, input logic e_valid);
    tick();
    peak_in       = pk;
    peak_valid_in = 1'b1;
    tick();
    peak_valid_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check_val({tag, " busy"}, busy_out, (k <= 8) ? 1 : 0);
      if (k == 9) begin
        check_val({tag, " note_on"}, note_on_out, e_on);
        check_val({tag, " note_off"}, note_off_out, e_off);
        if (e_off) check_val({tag, " off_note"}, off_note_out, e_off_note);
        check_val({tag, " note"}, note_out, e_note);
        check_val({tag, " note_valid"}, note_valid_out, e_valid);
      end else begin
        check_val({tag, " note_on idle"}, note_on_out, 0);
        check_val({tag, " note_off idle"}, note_off_out, 0);
      end
      if (k < 10) tick();
    end
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_in = 1'b0;
    check_val("reset note", note_out, 0);
    check_val("reset note_valid", note_valid_out, 0);
    check_val("reset busy", busy_out, 0);
    check_val("reset off_note", off_note_out, 0);
    check_val("reset drop", drop_out, 0);
    check_val("reset on", note_on_out, 0);

    // First note: three 750 Hz frames, 500 cycles apart.
    run_frame("s1f1", 13'd128, 0, 0, 0, 0, 0);
    repeat (490) tick();
    run_frame("s1f2", 13'd128, 0, 0, 0, 0, 0);
    repeat (490) tick();
    run_frame("s1f3", 13'd128, 1, 0, 0, 78, 1);

    // Change 78 -> 69 with simultaneous off/on.
    run_frame("s2f1", 13'd75, 0, 0, 0, 78, 1);
    run_frame("s2f2", 13'd75, 0, 0, 0, 78, 1);
    run_frame("s2f3", 13'd75, 1, 1, 78, 69, 1);
    run_frame("alt1", 13'd75, 0, 0, 0, 69, 1);
    run_frame("alt2", 13'd128, 0, 0, 0, 69, 1);
    run_frame("alt3", 13'd75, 0, 0, 0, 69, 1);

    // Out-of-range bins both resolve to NONE and release the note.
    run_frame("s3f1", 13'd4, 0, 0, 0, 69, 1);
    run_frame("s3f2", 13'd4, 0, 0, 0, 69, 1);
    run_frame("s3f3", 13'd800, 0, 1, 69, 69, 0);

    // Drop: second strobe at t+3 is discarded.
    tick();
    peak_in = 13'd128;
    peak_valid_in = 1'b1;
    tick();
    peak_valid_in = 1'b0;
    check_val("drop t1", drop_out, 0);
    tick();
    tick();
    peak_valid_in = 1'b1;
    tick();
    peak_valid_in = 1'b0;
    check_val("drop pulse", drop_out, 1);
    check_val("drop busy", busy_out, 1);
    tick();
    check_val("drop clear", drop_out, 0);
    repeat (4) tick();
    check_val("drop busy end", busy_out, 0);
    check_val("drop on", note_on_out, 0);
    check_val("drop valid", note_valid_out, 0);
    repeat (3) tick();
    run_frame("drop f2", 13'd128, 0, 0, 0, 69, 0);
    run_frame("drop f3", 13'd128, 1, 0, 0, 78, 1);

    // Reset at t+4 aborts the search.
    tick();
    peak_in = 13'd75;
    peak_valid_in = 1'b1;
    tick();
    peak_valid_in = 1'b0;
    repeat (3) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_val("rst note", note_out, 0);
    check_val("rst note_valid", note_valid_out, 0);
    check_val("rst busy", busy_out, 0);
    check_val("rst off_note", off_note_out, 0);
    for (int k = 0; k < 8; k++) begin
      check_val("rst no on", note_on_out, 0);
      check_val("rst no off", note_off_out, 0);
      tick();
    end
    run_frame("rst f1", 13'd128, 0, 0, 0, 0, 0);
    run_frame("rst f2", 13'd128, 0, 0, 0, 0, 0);
    run_frame("rst f3", 13'd128, 1, 0, 0, 78, 1);

    // STABLE_FRAMES=1: a single frame sets the note.
    tick();
    peak_in = 13'd75;
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    repeat (7) tick();
    check_val("sf1 on early", on2, 0);
    check_val("sf1 busy t8", busy2, 1);
    tick();
    check_val("sf1 on", on2, 1);
    check_val("sf1 note", note2, 69);
    check_val("sf1 valid", nvalid2, 1);
    check_val("sf1 off", off2, 0);
    tick();
    check_val("sf1 on clear", on2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
